// File: rtl/shift_pkg.sv
// Shared select, fill-mode and sequencer-state encodings for the
// multi-step shift register and its one-step datapath.
package shift_pkg;

    typedef enum logic [1:0] {
        SEL_LOAD  = 2'b00,
        SEL_RIGHT = 2'b01,
        SEL_LEFT  = 2'b10,
        SEL_HOLD  = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        FILL_EXT   = 2'b00,
        FILL_ROT   = 2'b01,
        FILL_ARITH = 2'b10,
        FILL_ZERO  = 2'b11
    } fill_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One shift step: next register value and outgoing bit for a given direction
// and fill mode. Bit 0 is the MSB; "right" moves data toward higher indices.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 36
) (
    input  logic [0:WIDTH-1] i_q,
    input  logic             i_left,
    input  fill_t            i_fill,
    input  logic             i_fill_l,
    input  logic             i_fill_r,
    output logic [0:WIDTH-1] o_q,
    output logic             o_sout
);

    logic w_fill_bit;

    always_comb begin
        w_fill_bit = 1'b0;
        o_q        = i_q;
        o_sout     = 1'b0;
        if (i_left) begin
            // Arithmetic left shift brings in zero, same as zero fill.
            case (i_fill)
                FILL_EXT: w_fill_bit = i_fill_r;
                FILL_ROT: w_fill_bit = i_q[0];
                default:  w_fill_bit = 1'b0;
            endcase
            o_q    = {i_q[1:WIDTH-1], w_fill_bit};
            o_sout = i_q[0];
        end else begin
            case (i_fill)
                FILL_EXT:   w_fill_bit = i_fill_l;
                FILL_ROT:   w_fill_bit = i_q[WIDTH-1];
                FILL_ARITH: w_fill_bit = i_q[0];
                default:    w_fill_bit = 1'b0;
            endcase
            o_q    = {w_fill_bit, i_q[0:WIDTH-2]};
            o_sout = i_q[WIDTH-1];
        end
    end

endmodule

// File: rtl/multi_step_shift_register.sv
// Universal shift register with per-edge LOAD/SHIFT/HOLD and a START/BUSY/DONE
// sequencer for N-place shifts.  IDLE | SEL acts each edge; RUN | autonomous steps.
module multi_step_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [0:WIDTH-1] i_d,
    input  logic [1:0]       i_sel,
    input  logic [1:0]       i_fill,
    input  logic             i_fill_l,
    input  logic             i_fill_r,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    output logic [0:WIDTH-1] o_q,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    state_t           r_state;
    logic [0:WIDTH-1] r_q;
    logic             r_sout;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic             r_left;
    fill_t            r_fill;

    state_t           w_state_nxt;
    logic [0:WIDTH-1] w_q_nxt;
    logic             w_sout_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_left_nxt;
    fill_t            w_fill_nxt;

    sel_t             w_sel;
    fill_t            w_fill_in;
    logic             w_step_left;
    fill_t            w_step_fill;
    logic [0:WIDTH-1] w_step_q;
    logic             w_step_sout;

    assign w_sel     = sel_t'(i_sel);
    assign w_fill_in = fill_t'(i_fill);

    // While running, direction and fill mode come from the latched copies.
    assign w_step_left = (r_state == RUN) ? r_left : (w_sel == SEL_LEFT);
    assign w_step_fill = (r_state == RUN) ? r_fill : w_fill_in;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q      (r_q),
        .i_left   (w_step_left),
        .i_fill   (w_step_fill),
        .i_fill_l (i_fill_l),
        .i_fill_r (i_fill_r),
        .o_q      (w_step_q),
        .o_sout   (w_step_sout)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_fill  <= FILL_EXT;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_sout  <= w_sout_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            r_left  <= w_left_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_sout_nxt  = r_sout;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_left_nxt  = r_left;
        w_fill_nxt  = r_fill;

        case (r_state)
            IDLE: begin
                if (i_start && (w_sel == SEL_RIGHT || w_sel == SEL_LEFT)) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = i_count;
                    w_left_nxt  = (w_sel == SEL_LEFT);
                    w_fill_nxt  = w_fill_in;
                end else begin
                    case (w_sel)
                        SEL_LOAD: w_q_nxt = i_d;
                        SEL_RIGHT, SEL_LEFT: begin
                            w_q_nxt    = w_step_q;
                            w_sout_nxt = w_step_sout;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (r_cnt != '0) begin
                    w_q_nxt    = w_step_q;
                    w_sout_nxt = w_step_sout;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end
                // Finishing on the last step, or immediately for a zero count.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_q    = r_q;
    assign o_sout = r_sout;
    assign o_busy = (r_state == RUN);
    assign o_done = r_done;

endmodule
